// File: rtl/sobel_row_sequencer.sv
// Sequences the three row-register reads and the single result write for every output pixel of a Sobel pass.
// Build option: define SOBEL_SEQ_PERF_CNT_EN to add the saturating busy-cycle counter output cycle_count.
module sobel_row_sequencer #(
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [DIM_W-1:0] img_cols,
  input  logic [DIM_W-1:0] img_rows,
  output logic             rd_req,
  output logic [1:0]       rd_row_sel,
  output logic [DIM_W-1:0] rd_row_idx,
  output logic [DIM_W-1:0] rd_col_idx,
  input  logic             rd_ack,
  output logic             wr_req,
  output logic [DIM_W-1:0] wr_row_idx,
  output logic [DIM_W-1:0] wr_col_idx,
  input  logic             wr_ack,
  output logic             busy,
`ifdef SOBEL_SEQ_PERF_CNT_EN
  output logic             done,
  output logic [31:0]      cycle_count
`else
  output logic             done
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD1  = 3'd1,
    S_RD2  = 3'd2,
    S_RD3  = 3'd3,
    S_WR   = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  localparam logic [DIM_W-1:0] ZERO_D  = {DIM_W{1'b0}};
  localparam logic [DIM_W-1:0] ONE_D   = {{(DIM_W-1){1'b0}}, 1'b1};
  localparam logic [DIM_W:0]   ONE_W   = {{DIM_W{1'b0}}, 1'b1};
  localparam logic [DIM_W:0]   TWO_W   = {{(DIM_W-1){1'b0}}, 2'b10};
  localparam logic [DIM_W:0]   THREE_W = {{(DIM_W-1){1'b0}}, 2'b11};

  state_t           state_r;
  logic [DIM_W-1:0] cols_r;
  logic [DIM_W-1:0] rows_r;
  logic [DIM_W-1:0] row_r;
  logic [DIM_W-1:0] col_r;

  logic [DIM_W:0]   col_next_s;
  logic [DIM_W:0]   row_lim_s;
  logic             col_more_s;
  logic             row_more_s;
  logic             dims_ok_s;

  // Dimension tests are done one bit wider so that k+1 and r+2 never wrap.
  always_comb begin
    col_next_s = {1'b0, col_r} + ONE_W;
    row_lim_s  = {1'b0, row_r} + TWO_W;
    col_more_s = (col_next_s < {1'b0, cols_r});
    row_more_s = (row_lim_s < {1'b0, rows_r});
    dims_ok_s  = ({1'b0, img_rows} >= THREE_W) && (img_cols != ZERO_D);
  end

  // Frame sequencer; every output is loaded on the transition into the state that owns it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= S_IDLE;
      cols_r     <= ZERO_D;
      rows_r     <= ZERO_D;
      row_r      <= ONE_D;
      col_r      <= ZERO_D;
      rd_req     <= 1'b0;
      rd_row_sel <= 2'd0;
      rd_row_idx <= ZERO_D;
      rd_col_idx <= ZERO_D;
      wr_req     <= 1'b0;
      wr_row_idx <= ZERO_D;
      wr_col_idx <= ZERO_D;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (go) begin
            cols_r <= img_cols;
            rows_r <= img_rows;
            row_r  <= ONE_D;
            col_r  <= ZERO_D;
            if (dims_ok_s) begin
              state_r    <= S_RD1;
              rd_req     <= 1'b1;
              rd_row_sel <= 2'd1;
              rd_row_idx <= ZERO_D;
              rd_col_idx <= ZERO_D;
              busy       <= 1'b1;
            end else begin
              state_r <= S_FIN;
            end
          end
        end
        S_RD1: begin
          if (rd_ack) begin
            state_r    <= S_RD2;
            rd_row_sel <= 2'd2;
            rd_row_idx <= row_r;
          end
        end
        S_RD2: begin
          if (rd_ack) begin
            state_r    <= S_RD3;
            rd_row_sel <= 2'd3;
            rd_row_idx <= row_r + ONE_D;
          end
        end
        S_RD3: begin
          if (rd_ack) begin
            state_r    <= S_WR;
            rd_req     <= 1'b0;
            rd_row_sel <= 2'd0;
            rd_row_idx <= ZERO_D;
            rd_col_idx <= ZERO_D;
            wr_req     <= 1'b1;
            wr_row_idx <= row_r;
            wr_col_idx <= col_r;
          end
        end
        S_WR: begin
          if (wr_ack) begin
            wr_req     <= 1'b0;
            wr_row_idx <= ZERO_D;
            wr_col_idx <= ZERO_D;
            if (col_more_s) begin
              state_r    <= S_RD1;
              col_r      <= col_next_s[DIM_W-1:0];
              rd_req     <= 1'b1;
              rd_row_sel <= 2'd1;
              rd_row_idx <= row_r - ONE_D;
              rd_col_idx <= col_next_s[DIM_W-1:0];
            end else if (row_more_s) begin
              // Next output row r+1 reads image row (r+1)-1, i.e. the current r.
              state_r    <= S_RD1;
              col_r      <= ZERO_D;
              row_r      <= row_r + ONE_D;
              rd_req     <= 1'b1;
              rd_row_sel <= 2'd1;
              rd_row_idx <= row_r;
              rd_col_idx <= ZERO_D;
            end else begin
              state_r <= S_FIN;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        S_FIN: begin
          // Entered with done already set after a real frame; a rejected frame raises it here first.
          if (done) begin
            done    <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          rd_req     <= 1'b0;
          rd_row_sel <= 2'd0;
          wr_req     <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

`ifdef SOBEL_SEQ_PERF_CNT_EN
  // Busy-cycle counter: cleared on an accepted go, saturating, held once the frame ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_count <= 32'h0000_0000;
    end else if ((state_r == S_IDLE) && go) begin
      cycle_count <= 32'h0000_0000;
    end else if (busy && (cycle_count != 32'hFFFF_FFFF)) begin
      cycle_count <= cycle_count + 32'h0000_0001;
    end
  end
`endif

endmodule

// File: doc/sobel_row_sequencer.md
SOBEL_ROW_SEQUENCER -- requirements
Module: sobel_row_sequencer

Interface
REQ-001 SHALL have parameter DIM_W, default 16, meaning the width of the image dimension inputs and the row/column index outputs.
REQ-002 SHALL have the following ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- go, input, 1: start pulse.
- img_cols, input, DIM_W: number of column steps per row.
- img_rows, input, DIM_W: number of input image rows.
- rd_req, output, 1: row-read request to the row-register fill path.
- rd_row_sel, output, 2: target row register; 1 = row1, 2 = row2, 3 = row3; 0 when idle.
- rd_row_idx, output, DIM_W: image row to read.
- rd_col_idx, output, DIM_W: column step to read.
- rd_ack, input, 1: read complete.
- wr_req, output, 1: request to write the accelerator result.
- wr_row_idx, output, DIM_W: output row.
- wr_col_idx, output, DIM_W: output column step.
- wr_ack, input, 1: write complete.
- busy, output, 1: a frame is in progress.
- done, output, 1: one-cycle end-of-frame pulse.

Function
REQ-003 SHALL implement states IDLE, RD1, RD2, RD3, WR, FIN.
REQ-004 IDLE SHALL move to RD1 on go=1 when img_rows>=3 and img_cols>=1; on go=1 with smaller dimensions it SHALL move to FIN without issuing any request.
REQ-005 SHALL latch img_cols and img_rows on the accepted go; later input changes SHALL NOT affect the frame in progress.
REQ-006 SHALL ignore go while busy=1.
REQ-007 SHALL keep an output-row counter r, starting at 1, and a column counter k, starting at 0.
REQ-008 In RDn, SHALL drive rd_req=1, rd_row_sel=n, rd_row_idx=r-2+n and rd_col_idx=k.
REQ-009 SHALL hold every rd_* output stable until rd_ack=1 is sampled; RDn SHALL then advance to RD(n+1), and RD3 to WR.
REQ-010 In WR, SHALL drive wr_req=1, wr_row_idx=r and wr_col_idx=k, held stable until wr_ack=1 is sampled.
REQ-011 On wr_ack=1, SHALL do exactly one of the following:
- if k<cols-1: set k=k+1 and go to RD1;
- else if r<rows-2: set k=0, r=r+1 and go to RD1;
- else: go to FIN.
REQ-012 rd_req and wr_req SHALL never be asserted in the same cycle.
REQ-013 Each request SHALL deassert in the cycle after its ack is sampled; the next request SHALL assert in that same cycle, with no idle bubble.
REQ-014 rd_ack and wr_ack SHALL be ignored unless the corresponding request is high.
REQ-015 An ack arriving in the same cycle the request first asserts SHALL be accepted, giving one cycle per transaction.
REQ-016 FIN SHALL assert done=1 for exactly one cycle and return to IDLE.
REQ-017 busy SHALL be 1 in RD1 through WR and 0 in IDLE and FIN.
REQ-018 A frame SHALL issue exactly 3*(rows-2)*cols reads and (rows-2)*cols writes.
REQ-019 Counters SHALL be DIM_W bits; the dimension comparisons SHALL NOT wrap at maximum values.
REQ-020 With zero-wait acks, the first rd_req SHALL assert in the cycle after go is sampled, and done SHALL assert in the cycle after the final wr_ack.

Reset
REQ-021 reset_n=0 SHALL immediately, without waiting for clk, force state IDLE, r=1, k=0 and all outputs 0, including rd_req, wr_req, busy, done, every index output and rd_row_sel.
REQ-022 Reset asserted mid-frame SHALL abandon the frame with no done pulse.
REQ-023 After reset_n deasserts, the block SHALL wait for a fresh go before starting a frame.

Configuration
REQ-024 With SOBEL_SEQ_PERF_CNT_EN defined, SHALL add output cycle_count (32 bits):
- clears on the accepted go;
- increments every cycle while busy=1;
- holds after done;
- saturates at 32'hFFFFFFFF;
- is 0 on reset.
REQ-025 Without SOBEL_SEQ_PERF_CNT_EN, the cycle_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-026 rows=3, cols=1, zero-wait acks: expect reads (sel,row,col) = (1,0,0), (2,1,0), (3,2,0); then a write at (1,0); done 5 cycles after go; cycle_count=4.
REQ-027 rows=4, cols=2: expect the write sequence (1,0), (1,1), (2,0), (2,1) and exactly 12 reads, with read rows 1,2,3 for output row 2.
REQ-028 rd_ack delayed 3 cycles on each read: rd_req and all rd_* outputs stay stable for 4 cycles per read, and an ack pulse sent during WR is ignored.
REQ-029 rows=2, cols=5: no rd_req or wr_req is issued, and done asserts 2 cycles after go.
REQ-030 Reset pulsed while in RD2: outputs go to 0 asynchronously, there is no done pulse, and a new go restarts the frame at (1,0,0).
REQ-031 go re-pulsed mid-frame and img_cols changed mid-frame: the transaction sequence is identical to the same frame run without these disturbances.
